// File: rtl/fpu_runner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_runner_pkg: shared types for the fpu_vector_runner vector sequencer.   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
package fpu_runner_pkg;

  // Widest operand a vector entry can carry; narrower FP_W builds zero-extend.
  localparam int FP_W_MAX = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_POS_INF = 2'd2;
  localparam logic [1:0] RM_NEG_INF = 2'd3;

  typedef struct packed {
    logic [FP_W_MAX-1:0] fpa;
    logic [FP_W_MAX-1:0] fpb;
    logic [FP_W_MAX-1:0] exp;
    op_e                 op;
    logic [1:0]          rm;
    logic                db;
    logic [4:0]          flags;
  } vec_t;

endpackage
`default_nettype wire

// File: rtl/fpu_vec_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_vec_mem: DEPTH x W vector store, synchronous write, asynchronous read.  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fpu_vec_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // No reset: contents must survive a mid-run reset of the sequencer.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/fpu_vector_runner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_vector_runner: walks stored vectors through the master FPU and scores. |
// | Option macro: FPU_RUNNER_FLAG_CHECK_EN (also compare IEEE flags).          |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fpu_vector_runner
  import fpu_runner_pkg::*;
#(
  parameter int FP_W    = 64,
  parameter int DEPTH   = 256,
  parameter int AW      = $clog2(DEPTH),
  parameter int RES_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [FP_W-1:0] wr_fpa,
  input  logic [FP_W-1:0] wr_fpb,
  input  logic [FP_W-1:0] wr_exp,
  input  logic [1:0]      wr_op,
  input  logic [1:0]      wr_rm,
  input  logic            wr_db,
  input  logic [4:0]      wr_flags,
  input  logic            start,
  input  logic [AW:0]     num_vec,
  output logic [FP_W-1:0] fpa,
  output logic [FP_W-1:0] fpb,
  output logic            db,
  output logic            normal,
  output logic            sub,
  output logic            fdiv,
  output logic [1:0]      rm,
  input  logic [FP_W-1:0] fp_add_out,
  input  logic [FP_W-1:0] fp_mul_out,
  input  logic [4:0]      ieee_add,
  input  logic [4:0]      ieee_mul,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     pass_cnt,
  output logic [AW:0]     fail_cnt,
  output logic            first_fail_vld,
  output logic [AW-1:0]   first_fail_idx
);

  localparam int          HALF    = FP_W / 2;
  localparam logic [3:0]  LAT     = 4'(RES_LAT);
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     nvec_q, nvec_d;
  logic [3:0]      wait_q, wait_d;
  logic [FP_W-1:0] fpa_q, fpa_d, fpb_q, fpb_d;
  logic            db_q, db_d, sub_q, sub_d, fdiv_q, fdiv_d, normal_q, normal_d;
  logic [1:0]      rm_q, rm_d;
  logic [AW:0]     pass_q, pass_d, fail_q, fail_d;
  logic            ffv_q, ffv_d;
  logic [AW-1:0]   ffi_q, ffi_d;

  vec_t            wr_vec, rd_vec;
  logic            mem_we, is_busy, res_match, flag_match, vec_ok;
  logic [FP_W-1:0] res_sel;
  logic [4:0]      flag_sel;

  assign is_busy = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign mem_we  = wr_en && !is_busy;

  always_comb begin
    wr_vec     = '0;
    wr_vec.fpa = FP_W_MAX'(wr_fpa);
    wr_vec.fpb = FP_W_MAX'(wr_fpb);
    wr_vec.exp = FP_W_MAX'(wr_exp);
    wr_vec.op  = op_e'(wr_op);
    wr_vec.rm  = wr_rm;
    wr_vec.db  = wr_db;
`ifdef FPU_RUNNER_FLAG_CHECK_EN
    wr_vec.flags = wr_flags;
`endif
  end

  fpu_vec_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     ($bits(vec_t))
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_vec),
    .raddr (idx_q),
    .rdata (rd_vec)
  );

  // Single precision lives in the upper half; the lower half is don't-care.
  always_comb begin
    if ((rd_vec.op == OP_ADD) || (rd_vec.op == OP_SUB)) begin
      res_sel  = fp_add_out;
      flag_sel = ieee_add;
    end else begin
      res_sel  = fp_mul_out;
      flag_sel = ieee_mul;
    end
    if (rd_vec.db) begin
      res_match = (res_sel == rd_vec.exp[FP_W-1:0]);
    end else begin
      res_match = (res_sel[FP_W-1:HALF] == rd_vec.exp[FP_W-1:HALF]);
    end
`ifdef FPU_RUNNER_FLAG_CHECK_EN
    flag_match = (flag_sel == rd_vec.flags);
`else
    flag_match = 1'b1;
`endif
    vec_ok = res_match && flag_match;
  end

`ifndef FPU_RUNNER_FLAG_CHECK_EN
  logic unused_flags;
  assign unused_flags = ^{wr_flags, flag_sel, rd_vec.flags};
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nvec_d   = nvec_q;
    wait_d   = wait_q;
    fpa_d    = fpa_q;
    fpb_d    = fpb_q;
    db_d     = db_q;
    sub_d    = sub_q;
    fdiv_d   = fdiv_q;
    normal_d = normal_q;
    rm_d     = rm_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nvec_d  = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          state_d = (num_vec == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        fpa_d    = rd_vec.fpa[FP_W-1:0];
        fpb_d    = rd_vec.fpb[FP_W-1:0];
        db_d     = rd_vec.db;
        rm_d     = rd_vec.rm;
        sub_d    = (rd_vec.op == OP_SUB);
        fdiv_d   = (rd_vec.op == OP_DIV);
        normal_d = 1'b1;
        wait_d   = LAT;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (vec_ok) begin
          pass_d = pass_q + (AW+1)'(1);
        end else begin
          fail_d = fail_q + (AW+1)'(1);
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        if ({1'b0, idx_q} == (nvec_q - (AW+1)'(1))) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      nvec_q   <= '0;
      wait_q   <= '0;
      fpa_q    <= '0;
      fpb_q    <= '0;
      db_q     <= 1'b0;
      sub_q    <= 1'b0;
      fdiv_q   <= 1'b0;
      normal_q <= 1'b1;
      rm_q     <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ffv_q    <= 1'b0;
      ffi_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nvec_q   <= nvec_d;
      wait_q   <= wait_d;
      fpa_q    <= fpa_d;
      fpb_q    <= fpb_d;
      db_q     <= db_d;
      sub_q    <= sub_d;
      fdiv_q   <= fdiv_d;
      normal_q <= normal_d;
      rm_q     <= rm_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
    end
  end

  assign fpa            = fpa_q;
  assign fpb            = fpb_q;
  assign db             = db_q;
  assign sub            = sub_q;
  assign fdiv           = fdiv_q;
  assign normal         = normal_q;
  assign rm             = rm_q;
  assign busy           = is_busy;
  assign done           = (state_q == S_DONE);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_vector_runner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpu_vector_runner: directed bench with a real-arithmetic FPU stand-in.   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_fpu_vector_runner;
  import fpu_runner_pkg::*;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int RES_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_fpa, wr_fpb, wr_exp;
  logic [1:0]    wr_op, wr_rm;
  logic          wr_db;
  logic [4:0]    wr_flags;
  logic          start;
  logic [AW:0]   num_vec;
  logic [63:0]   fpa, fpb;
  logic          db, normal, sub, fdiv;
  logic [1:0]    rm;
  logic [63:0]   add_q, mul_q;
  logic [4:0]    mflags;
  logic          busy, done;
  logic [AW:0]   pass_cnt, fail_cnt;
  logic          first_fail_vld;
  logic [AW-1:0] first_fail_idx;

  int n_chk = 0;
  int n_err = 0;
  int dc;

  logic [63:0] m_fpa [DEPTH];
  logic [63:0] m_fpb [DEPTH];
  logic [63:0] m_exp [DEPTH];
  logic [1:0]  m_op  [DEPTH];
  logic [1:0]  m_rm  [DEPTH];
  logic        m_db  [DEPTH];
  logic [4:0]  m_fl  [DEPTH];

  always #5 clk = ~clk;

  fpu_vector_runner #(
    .FP_W(64), .DEPTH(DEPTH), .AW(AW), .RES_LAT(RES_LAT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_fpa(wr_fpa), .wr_fpb(wr_fpb), .wr_exp(wr_exp), .wr_op(wr_op),
    .wr_rm(wr_rm), .wr_db(wr_db), .wr_flags(wr_flags), .start(start),
    .num_vec(num_vec), .fpa(fpa), .fpb(fpb), .db(db), .normal(normal),
    .sub(sub), .fdiv(fdiv), .rm(rm), .fp_add_out(add_q), .fp_mul_out(mul_q),
    .ieee_add(mflags), .ieee_mul(mflags), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx)
  );

  function automatic logic [63:0] sp2dp(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return {s[31], 63'd0};
    e = 11'(s[30:23]) + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] t;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    t = d[62:52] - 11'd896;
    return {d[63], t[7:0], d[51:29]};
  endfunction

  // Stand-in for master: exact real arithmetic, single results in the upper half.
  function automatic logic [63:0] calc(input logic [63:0] a, input logic [63:0] b,
                                       input logic is_mul, input logic s,
                                       input logic dv, input logic d);
    real x, y, r;
    if (d) begin
      x = $bitstoreal(a);
      y = $bitstoreal(b);
    end else begin
      x = $bitstoreal(sp2dp(a[63:32]));
      y = $bitstoreal(sp2dp(b[63:32]));
    end
    if (is_mul) r = dv ? x / y : x * y;
    else        r = s ? x - y : x + y;
    if (d) return $realtobits(r);
    return {dp2sp($realtobits(r)), 32'hDEADBEEF};
  endfunction

  always @(posedge clk) begin
    add_q <= calc(fpa, fpb, 1'b0, sub, fdiv, db);
    mul_q <= calc(fpa, fpb, 1'b1, sub, fdiv, db);
  end

  function automatic bit vec_pass(input int i);
    logic [63:0] r;
    bit ok;
    r  = calc(m_fpa[i], m_fpb[i], m_op[i][1], m_op[i] == OP_SUB, m_op[i] == OP_DIV, m_db[i]);
    ok = m_db[i] ? (r == m_exp[i]) : (r[63:32] == m_exp[i][63:32]);
`ifdef FPU_RUNNER_FLAG_CHECK_EN
    ok = ok && (m_fl[i] == mflags);
`endif
    return ok;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_fpa"}, fpa, 64'd0);
    check({nm, "_fpb"}, fpb, 64'd0);
    check({nm, "_ctl"}, 64'({db, sub, fdiv, rm, busy, done}), 64'd0);
    check({nm, "_normal"}, 64'(normal), 64'd1);
    check({nm, "_cnt"}, 64'({pass_cnt, fail_cnt, first_fail_vld, first_fail_idx}), 64'd0);
  endtask

  task automatic wr(input int a, input logic [63:0] fa, input logic [63:0] fb,
                    input logic [63:0] ex, input logic [1:0] op, input logic [1:0] rmv,
                    input logic dbv, input logic [4:0] fl);
    wr_en = 1'b1; wr_addr = AW'(a); wr_fpa = fa; wr_fpb = fb; wr_exp = ex;
    wr_op = op; wr_rm = rmv; wr_db = dbv; wr_flags = fl;
    @(negedge clk);
    wr_en = 1'b0;
    m_fpa[a] = fa; m_fpb[a] = fb; m_exp[a] = ex;
    m_op[a] = op; m_rm[a] = rmv; m_db[a] = dbv; m_fl[a] = fl;
  endtask

  task automatic fill(input int cnt);
    real x;
    logic [63:0] a, b, e;
    logic [1:0] op;
    logic dbv;
    for (int i = 0; i < cnt; i++) begin
      x   = real'(i + 1);
      op  = 2'(i % 4);
      dbv = (i % 3 != 0);
      if (dbv) begin
        a = $realtobits(x);
        b = $realtobits(2.0);
      end else begin
        a = {dp2sp($realtobits(x)), dp2sp($realtobits(x))};
        b = {2{32'h40000000}};
      end
      e = calc(a, b, op[1], op == OP_SUB, op == OP_DIV, dbv);
      if (!dbv) e[31:0] = 32'h0BAD0BAD;
      if (i == 3 || i == 7) e[40] = ~e[40];
      wr(i, a, b, e, op, 2'(i % 4), dbv, 5'd0);
    end
  endtask

  // Per-cycle compare against the run schedule: vector v occupies RES_LAT+2 cycles.
  task automatic run(input int nreq, input int gl_c, input int rst_c, output int done_c);
    int n, per, total, cv, v, ep, ef, fv, fi;
    n = (nreq > DEPTH) ? DEPTH : nreq;
    per = RES_LAT + 2;
    total = n * per;
    cv = 0; ep = 0; ef = 0; fv = 0; fi = 0; done_c = -1;
    @(negedge clk);
    start = 1'b1;
    num_vec = (AW+1)'(nreq);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      while (cv < n && cv < (c - 1) / per) begin
        if (vec_pass(cv)) ep++;
        else begin
          ef++;
          if (fv == 0) begin fv = 1; fi = cv; end
        end
        cv++;
      end
      check("busy", 64'(busy), 64'(c <= total));
      check("done", 64'(done), 64'(c == total + 1));
      if (done) done_c = c;
      if (n > 0 && (c > total || (c - 1) % per != 0)) begin
        v = ((c - 1) / per < n) ? (c - 1) / per : n - 1;
        check("fpa", fpa, m_fpa[v]);
        check("fpb", fpb, m_fpb[v]);
        check("drv_ctl", 64'({db, rm, sub, fdiv, normal}),
              64'({m_db[v], m_rm[v], m_op[v] == OP_SUB, m_op[v] == OP_DIV, 1'b1}));
      end
      check("pass_cnt", 64'(pass_cnt), 64'(ep));
      check("fail_cnt", 64'(fail_cnt), 64'(ef));
      check("ff_vld", 64'(first_fail_vld), 64'(fv));
      if (fv != 0) check("ff_idx", 64'(first_fail_idx), 64'(fi));
      if (c == gl_c) begin
        start = 1'b1; num_vec = '0;
        wr_en = 1'b1; wr_addr = AW'(3); wr_fpa = 64'h7FF0_0000_0000_0001;
        wr_fpb = 64'd0; wr_exp = 64'd0; wr_op = OP_ADD; wr_db = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_fpa = '0; wr_fpb = '0; wr_exp = '0;
    wr_op = '0; wr_rm = '0; wr_db = 1'b0; wr_flags = '0; start = 1'b0; num_vec = '0;
    mflags = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    // 3.0 + 3.0 = 6.0, double
    wr(0, 64'h4008000000000000, 64'h4008000000000000, 64'h4018000000000000,
       OP_ADD, RM_NEAREST, 1'b1, 5'd0);
    run(1, 0, 0, dc);
    check("t1_done_cycle", 64'(dc), 64'd4);
    check("t1_pass", 64'(pass_cnt), 64'd1);
    check("t1_fail", 64'(fail_cnt), 64'd0);

    // 1.5f + 2.5f = 4.0f, lower-half expectation is junk
    wr(0, 64'h3FC000003FC00000, 64'h4020000040200000, 64'h40800000FFFFFFFF,
       OP_ADD, RM_ZERO, 1'b0, 5'd0);
    run(1, 0, 0, dc);
    check("t2_pass", 64'(pass_cnt), 64'd1);
    check("t2_fail", 64'(fail_cnt), 64'd0);

    // add, sub, mul (wrong expectation), div
    wr(0, 64'h4008000000000000, 64'h4008000000000000, 64'h4018000000000000, OP_ADD, RM_NEAREST, 1'b1, 5'd0);
    wr(1, 64'h4014000000000000, 64'h4008000000000000, 64'h4000000000000000, OP_SUB, RM_ZERO,    1'b1, 5'd0);
    wr(2, 64'h4008000000000000, 64'h4008000000000000, 64'h4022000000000001, OP_MUL, RM_POS_INF, 1'b1, 5'd0);
    wr(3, 64'h4018000000000000, 64'h4008000000000000, 64'h4000000000000000, OP_DIV, RM_NEG_INF, 1'b1, 5'd0);
    run(4, 6, 0, dc);
    check("t3_done_cycle", 64'(dc), 64'd13);
    check("t3_pass", 64'(pass_cnt), 64'd3);
    check("t3_fail", 64'(fail_cnt), 64'd1);
    check("t3_ff_idx", 64'(first_fail_idx), 64'd2);
    run(4, 0, 0, dc);
    check("t3b_pass", 64'(pass_cnt), 64'd3);
    check("t3b_fail", 64'(fail_cnt), 64'd1);

    run(0, 0, 0, dc);
    check("t4_done_cycle", 64'(dc), 64'd1);
    check("t4_cnt", 64'({pass_cnt, fail_cnt}), 64'd0);

    // reset during WAIT of vector 5 (idx 4), then a clean rerun
    fill(10);
    run(10, 0, 14, dc);
    run(10, 0, 0, dc);
    check("t5_pass", 64'(pass_cnt), 64'd8);
    check("t5_fail", 64'(fail_cnt), 64'd2);
    check("t5_ff_idx", 64'(first_fail_idx), 64'd3);

    fill(16);
    run(31, 0, 0, dc);
    check("t6_done_cycle", 64'(dc), 64'd49);
    check("t6_pass", 64'(pass_cnt), 64'd14);
    check("t6_fail", 64'(fail_cnt), 64'd2);

    // correct result, expected flags differ from master's
    wr(0, 64'h4008000000000000, 64'h4008000000000000, 64'h4018000000000000,
       OP_ADD, RM_NEAREST, 1'b1, 5'b00001);
    run(1, 0, 0, dc);
`ifdef FPU_RUNNER_FLAG_CHECK_EN
    check("t7_fail", 64'(fail_cnt), 64'd1);
`else
    check("t7_pass", 64'(pass_cnt), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
